// File: rtl/tetris_score_pkg.sv
// rtl/tetris_score_pkg.sv - score addends, FSM encoding and single-digit BCD add
package tetris_score_pkg;

  localparam logic [15:0] ADDEND_1_LINE  = 16'h0010;
  localparam logic [15:0] ADDEND_2_LINES = 16'h0030;
  localparam logic [15:0] ADDEND_3_LINES = 16'h0050;
  localparam logic [15:0] ADDEND_4_LINES = 16'h0080;
  localparam logic [15:0] ADDEND_DROP    = 16'h0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD    = 2'd1,
    COMMIT = 2'd2
  } score_fsm_e;

  // Returns {cout, digit}; a decimal carry is corrected by adding 6.
  function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                input logic cin);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (sum > 5'd9) begin
      bcd_digit_add = {1'b1, 4'(sum + 5'd6)};
    end else begin
      bcd_digit_add = {1'b0, sum[3:0]};
    end
  endfunction

  function automatic logic [15:0] lines_addend(input logic [2:0] cnt);
    case (cnt)
      3'd1:    lines_addend = ADDEND_1_LINE;
      3'd2:    lines_addend = ADDEND_2_LINES;
      3'd3:    lines_addend = ADDEND_3_LINES;
      3'd4:    lines_addend = ADDEND_4_LINES;
      default: lines_addend = 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - one-digit combinational BCD adder
module bcd_digit_adder
  import tetris_score_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  always_comb begin
    {cout, sum} = bcd_digit_add(a, b, cin);
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// rtl/bcd_score_keeper.sv - digit-serial packed-BCD score and high score keeper
module bcd_score_keeper
  import tetris_score_pkg::*;
#(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [4*NUM_DIGITS-1:0] SAT_VALUE  = 16'h9999
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    game_clr,
  input  logic                    lines_valid,
  input  logic [2:0]              lines_cnt,
  input  logic                    drop_pt,
  output logic                    busy,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] hi_score,
  output logic                    saturated
);

  localparam int W = 4 * NUM_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  score_fsm_e       state;
  logic [W-1:0]     addend;
  logic [W-1:0]     work;
  logic [IDX_W-1:0] dig_idx;
  logic             carry;
  logic             pend_drop;

  logic             idle;
  logic             lines_ok;
  logic             lines_take;
  logic             drop_take;
  logic             pend_take;
  logic [3:0]       dig_a;
  logic [3:0]       dig_b;
  logic [3:0]       dig_sum;
  logic             dig_cout;

  assign idle = (state == IDLE);
  assign busy = !idle;

  always_comb begin
    lines_ok   = lines_valid && (lines_cnt >= 3'd1) && (lines_cnt <= 3'd4);
    lines_take = idle && lines_ok;
    drop_take  = idle && !lines_ok && drop_pt;
    pend_take  = idle && !lines_ok && !drop_pt && pend_drop;
  end

  // The single adder walks the digits; score is only written in COMMIT.
  always_comb begin
    dig_a = score[{dig_idx, 2'b00} +: 4];
    dig_b = addend[{dig_idx, 2'b00} +: 4];
  end

  bcd_digit_adder u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addend    <= '0;
      work      <= '0;
      dig_idx   <= '0;
      carry     <= 1'b0;
      pend_drop <= 1'b0;
      score     <= '0;
      hi_score  <= '0;
      saturated <= 1'b0;
    end else if (game_clr) begin
      // Packed BCD orders the same as binary, so a plain compare works.
      hi_score  <= (score > hi_score) ? score : hi_score;
      score     <= '0;
      saturated <= 1'b0;
      pend_drop <= 1'b0;
      state     <= IDLE;
      dig_idx   <= '0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (lines_take || drop_take || pend_take) begin
            addend  <= lines_take ? W'(lines_addend(lines_cnt)) : W'(ADDEND_DROP);
            dig_idx <= '0;
            carry   <= 1'b0;
            state   <= ADD;
          end
        end
        ADD: begin
          work[{dig_idx, 2'b00} +: 4] <= dig_sum;
          carry   <= dig_cout;
          dig_idx <= dig_idx + 1'b1;
          if (dig_idx == LAST_IDX) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          if (carry) begin
            score     <= SAT_VALUE;
            saturated <= 1'b1;
          end else begin
            score <= work;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (pend_take) begin
        pend_drop <= 1'b0;
      end else if (drop_pt && (!idle || lines_ok)) begin
        pend_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_score_keeper.sv
// tb/tb_bcd_score_keeper.sv - scoreboard bench for bcd_score_keeper
module tb_bcd_score_keeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        game_clr = 1'b0;
  logic        lines_valid = 1'b0;
  logic [2:0]  lines_cnt = 3'd0;
  logic        drop_pt = 1'b0;
  logic        busy;
  logic [15:0] score;
  logic [15:0] hi_score;
  logic        saturated;

  typedef struct {
    logic [15:0] score;
    logic [15:0] hi;
    logic        sat;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_hi = 16'h0000;
  logic        prev_busy = 1'b0;

  bcd_score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .game_clr    (game_clr),
    .lines_valid (lines_valid),
    .lines_cnt   (lines_cnt),
    .drop_pt     (drop_pt),
    .busy        (busy),
    .score       (score),
    .hi_score    (hi_score),
    .saturated   (saturated)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] int2bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic push(input logic [15:0] s, input logic [15:0] h, input logic sat,
                      input string nm);
    exp_t e;
    e.score = s;
    e.hi    = h;
    e.sat   = sat;
    e.name  = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue one event, register its completion result, wait out the 6-cycle spacing.
  task automatic fire(input bit lines, input int cnt, input bit drop,
                      input logic [15:0] exp_s, input logic exp_sat, input string nm);
    push(exp_s, exp_hi, exp_sat, nm);
    lines_valid = lines;
    lines_cnt   = 3'(cnt);
    drop_pt     = drop;
    @(negedge clk);
    lines_valid = 1'b0;
    lines_cnt   = 3'd0;
    drop_pt     = 1'b0;
    tick(5);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_hi = 16'h0000;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    game_clr = 1'b1;
    @(negedge clk);
    game_clr = 1'b0;
  endtask

  // Monitor: every completion (busy falling) must match the next queued expectation.
  always @(negedge clk) begin
    if (prev_busy && !busy) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: score=%h hi=%h sat=%b with nothing expected",
                 score, hi_score, saturated);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (score !== e.score || hi_score !== e.hi || saturated !== e.sat) begin
          failures++;
          $display("FAIL %s: actual score=%h hi=%h sat=%b required score=%h hi=%h sat=%b",
                   e.name, score, hi_score, saturated, e.score, e.hi, e.sat);
        end
      end
    end
    prev_busy = busy;
  end

  logic [15:0] t2[10] = '{16'h0090, 16'h0091, 16'h0092, 16'h0093, 16'h0094,
                          16'h0095, 16'h0096, 16'h0097, 16'h0098, 16'h0099};

  initial begin
    int v;
    tick(3);
    check("reset_score", 32'(score), 32'h0);
    check("reset_hi", 32'(hi_score), 32'h0);
    check("reset_sat", 32'(saturated), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    tick(1);

    // 1: four lines, latency and no partial display
    push(16'h0080, 16'h0000, 1'b0, "t1_commit");
    lines_valid = 1'b1;
    lines_cnt   = 3'd4;
    @(negedge clk);
    lines_valid = 1'b0;
    lines_cnt   = 3'd0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1_busy_e%0d", i), 32'(busy), 32'h1);
      check($sformatf("t1_hold_e%0d", i), 32'(score), 32'h0);
      @(negedge clk);
    end
    check("t1_score_e5", 32'(score), 32'h0080);
    tick(1);

    // 2: 0x0080 -> 0x0090 -> drops up to 0x0100
    for (int i = 0; i < 10; i++) begin
      fire(i == 0, (i == 0) ? 1 : 0, i != 0, t2[i], 1'b0, $sformatf("t2_step%0d", i));
    end
    fire(1'b0, 0, 1'b1, 16'h0100, 1'b0, "t2_carry_0100");

    // 3: lines + drop together, extra drop during add is lost
    pulse_rst();
    push(16'h0030, 16'h0000, 1'b0, "t3_lines");
    push(16'h0031, 16'h0000, 1'b0, "t3_pend_drop");
    lines_valid = 1'b1;
    lines_cnt   = 3'd2;
    drop_pt     = 1'b1;
    @(negedge clk);
    lines_valid = 1'b0;
    lines_cnt   = 3'd0;
    drop_pt     = 1'b0;
    tick(2);
    drop_pt = 1'b1;
    @(negedge clk);
    drop_pt = 1'b0;
    tick(9);
    check("t3_score_after_pend", 32'(score), 32'h0031);
    check("t3_idle", 32'(busy), 32'h0);
    tick(7);
    check("t3_lost_drop", 32'(score), 32'h0031);

    // 4: build 0x9990 then saturate
    pulse_rst();
    v = 0;
    for (int i = 0; i < 127; i++) begin
      int c;
      c = (i < 124) ? 4 : (i == 124) ? 3 : 1;
      v += (c == 4) ? 80 : (c == 3) ? 50 : 10;
      fire(1'b1, c, 1'b0, int2bcd(v), 1'b0, "t4_build");
    end
    check("t4_preload", 32'(score), 32'h9990);
    fire(1'b1, 1, 1'b0, 16'h9999, 1'b1, "t4_saturate");
    check("t4_sat_flag", 32'(saturated), 32'h1);
    fire(1'b0, 0, 1'b1, 16'h9999, 1'b1, "t4_sat_hold");

    // 5: hi_score fold, abort of an in-flight add
    pulse_rst();
    fire(1'b1, 4, 1'b0, 16'h0080, 1'b0, "t5_a");
    fire(1'b1, 4, 1'b0, 16'h0160, 1'b0, "t5_b");
    fire(1'b1, 4, 1'b0, 16'h0240, 1'b0, "t5_c");
    fire(1'b1, 3, 1'b0, 16'h0290, 1'b0, "t5_d");
    fire(1'b1, 1, 1'b0, 16'h0300, 1'b0, "t5_e");
    pulse_clr();
    exp_hi = 16'h0300;
    check("t5_hi_0300", 32'(hi_score), 32'h0300);
    check("t5_clr_score", 32'(score), 32'h0);
    v = 0;
    for (int i = 0; i < 7; i++) begin
      v += (i < 5) ? 80 : 10;
      fire(1'b1, (i < 5) ? 4 : 1, 1'b0, int2bcd(v), 1'b0, "t5_build");
    end
    check("t5_score_0420", 32'(score), 32'h0420);
    push(16'h0000, 16'h0420, 1'b0, "t5_abort");
    lines_valid = 1'b1;
    lines_cnt   = 3'd1;
    @(negedge clk);
    lines_valid = 1'b0;
    lines_cnt   = 3'd0;
    tick(1);
    pulse_clr();
    exp_hi = 16'h0420;
    check("t5_abort_idle", 32'(busy), 32'h0);
    tick(8);
    check("t5_abort_score", 32'(score), 32'h0);
    fire(1'b1, 4, 1'b0, 16'h0080, 1'b0, "t5_f");
    fire(1'b1, 1, 1'b0, 16'h0090, 1'b0, "t5_g");
    fire(1'b1, 1, 1'b0, 16'h0100, 1'b0, "t5_h");
    pulse_clr();
    check("t5_hi_kept", 32'(hi_score), 32'h0420);
    check("t5_clr2_score", 32'(score), 32'h0);

    // 6: invalid line counts are ignored, then async reset mid-add
    fire(1'b0, 0, 1'b1, 16'h0001, 1'b0, "t6_seed");
    foreach (t2[i]) begin
      if (i < 3) begin
        lines_valid = 1'b1;
        lines_cnt   = (i == 0) ? 3'd0 : (i == 1) ? 3'd5 : 3'd7;
        @(negedge clk);
        lines_valid = 1'b0;
        lines_cnt   = 3'd0;
        for (int k = 0; k < 7; k++) begin
          if (busy !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL t6_ignored_busy: actual=%b required=0 cnt_case=%0d", busy, i);
          end
          @(negedge clk);
        end
        check($sformatf("t6_ignored_score%0d", i), 32'(score), 32'h0001);
      end
    end
    push(16'h0000, 16'h0000, 1'b0, "t6_rst_abort");
    lines_valid = 1'b1;
    lines_cnt   = 3'd4;
    @(negedge clk);
    lines_valid = 1'b0;
    lines_cnt   = 3'd0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_score", 32'(score), 32'h0);
    check("t6_rst_hi", 32'(hi_score), 32'h0);
    check("t6_rst_sat", 32'(saturated), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
